regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
Controller in front of the 32x32 two-read/one-write register file (regfile).
- Shares the single write port between a core requester (A) and a debug requester (B) using round-robin.
- Lends read port 2 to a debug read requester whenever the core does not need it.
- Runs a hardware clear sweep that zeroes registers 1..NUM_REGS-1 after reset or on request.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, number of registers; register 0 is hardwired zero

Ports:
Clk  in  1  clock, positive edge
Reset_n  in  1  asynchronous active-low reset
InitReq  in  1  start clear sweep (sampled in RUN only)
InitBusy  out  1  high while sweep is in progress
AWrValid  in  1  core write request
AWrReady  out  1  core write accepted this cycle
AWrAddr  in  ADDR_WIDTH  core write address
AWrData  in  DATA_WIDTH  core write data
BWrValid  in  1  debug write request
BWrReady  out  1  debug write accepted this cycle
BWrAddr  in  ADDR_WIDTH  debug write address
BWrData  in  DATA_WIDTH  debug write data
CoreRdAddr1  in  ADDR_WIDTH  core read address, port 1
CoreRdAddr2  in  ADDR_WIDTH  core read address, port 2
CoreRdUse2  in  1  core needs port 2 this cycle
CoreRdData1  out  DATA_WIDTH  = ReadData1
CoreRdData2  out  DATA_WIDTH  = ReadData2
BRdValid  in  1  debug read request
BRdReady  out  1  debug read accepted
BRdAddr  in  ADDR_WIDTH  debug read address
BRdData  out  DATA_WIDTH  registered debug read result
BRdDataValid  out  1  one-cycle pulse, cycle after accept
ReadRegister1  out  ADDR_WIDTH  to regfile
ReadRegister2  out  ADDR_WIDTH  to regfile
ReadData1  in  DATA_WIDTH  from regfile (combinational read)
ReadData2  in  DATA_WIDTH  from regfile
WriteRegister  out  ADDR_WIDTH  to regfile
WriteData  out  DATA_WIDTH  to regfile
RegWrite  out  1  to regfile; write occurs on posedge Clk

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=INIT, sweep counter=1, round-robin pointer=A.
  - BRdData=0, BRdDataValid=0.
  - Combinational outputs follow from state: InitBusy=1; AWrReady, BWrReady, BRdReady=0.
- FSM states: INIT and RUN.
  - INIT:
    - WriteRegister=counter, WriteData=0, RegWrite=1.
    - Counter increments each Clk.
    - After writing NUM_REGS-1 the next state is RUN (31 cycles for defaults). The counter reloads to 1.
    - All readies are 0. Incoming requests stay pending.
  - RUN: InitReq=1 at a Clk edge moves the FSM to INIT with counter=1. Any write granted in that same cycle still completes.
- Reset mid-sweep restarts the sweep from register 1.
- Write arbitration (RUN only; grant is combinational from valids and the registered pointer):
  - One valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
  - After any grant, the pointer becomes the other requester.
  - Granted Ready=1. WriteRegister/WriteData = granted address/data. RegWrite=1. The write lands at that edge; latency is 0 cycles from handshake.
- Address 0 write: accepted (Ready=1, pointer updates), but RegWrite=0.
- Requester obligation: hold Valid/Addr/Data stable until Ready. Deasserting Valid before Ready is permitted and simply withdraws the request.
- No grant: RegWrite=0, WriteRegister=0, WriteData=0.
- Read sharing:
  - ReadRegister1 = CoreRdAddr1 always.
  - BRdReady = (state==RUN) && !CoreRdUse2.
  - On BRdValid&&BRdReady: ReadRegister2=BRdAddr, ReadData2 is captured into BRdData at the edge, and BRdDataValid=1 the following cycle only. Otherwise ReadRegister2=CoreRdAddr2.
  - CoreRdData2 is invalid for the core during a debug read cycle; the core signalled it did not need it.
- Same-cycle read/write of the same address: the read returns the old value (write-first is not provided).
- Back-to-back debug reads are allowed, one per cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH and NUM_REGS defaults.
  - The state enum {INIT, RUN}.
  - The requester-id enum {REQ_A, REQ_B}.
- One sub-module, rr_arbiter2: 2-way round-robin grant plus pointer register, clocked by Clk, reset by Reset_n.

Test Plan:
1. Reset, then idle 31 cycles. Require InitBusy=1 for exactly 31 cycles. Require RegWrite with WriteRegister 1..31 and WriteData 0, then RUN.
2. After init, AWrValid with addr 2, data 42, held. Require AWrReady the same cycle and core read of reg 2 = 42 next cycle. During init, a held request must see AWrReady=0 until RUN.
3. A and B both valid every cycle (A: addr 3, data 10; B: addr 4, data 20) for 4 cycles. Require grants A,B,A,B with pointer starting at A and no cycle with both Ready.
4. BWrValid addr 0, data 15. Require BWrReady=1, RegWrite=0, and reg 0 reads 0.
5. Reg 5 holds 77. BRdValid addr 5 with CoreRdUse2=1 for 2 cycles, then 0. Require BRdReady=0 for 2 cycles, then ReadRegister2=5 and BRdData=77 with a one-cycle BRdDataValid pulse.
6. Assert InitReq at cycle 10 of RUN, then pull Reset_n low mid-sweep. Require an immediate return to InitBusy=1 and a full 31-write sweep; regs 1..31 read 0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file port controller.
package regfile_pkg;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_NUM_REGS   = 32;

   typedef enum logic {INIT, RUN} state_e;

   typedef enum logic {REQ_A, REQ_B} req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant from valids and a
// registered pointer that flips to the other requester after any grant.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic Clk,
   input  logic Reset_n,
   input  logic en,
   input  logic a_valid,
   input  logic b_valid,
   output logic a_grant,
   output logic b_grant
);

   req_id_e ptr_q, ptr_d;

   always_comb begin
      a_grant = en && a_valid && (!b_valid || (ptr_q == REQ_A));
      b_grant = en && b_valid && (!a_valid || (ptr_q == REQ_B));
      ptr_d   = ptr_q;
      if (a_grant)      ptr_d = REQ_B;
      else if (b_grant) ptr_d = REQ_A;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) ptr_q <= REQ_A;
      else          ptr_q <= ptr_d;
   end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Front-end for the 2R/1W regfile: write-port round-robin, debug borrowing of
// read port 2, and a zeroing sweep of registers 1..NUM_REGS-1.
module regfile_port_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int NUM_REGS   = RF_NUM_REGS
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  InitReq,
   output logic                  InitBusy,
   input  logic                  AWrValid,
   output logic                  AWrReady,
   input  logic [ADDR_WIDTH-1:0] AWrAddr,
   input  logic [DATA_WIDTH-1:0] AWrData,
   input  logic                  BWrValid,
   output logic                  BWrReady,
   input  logic [ADDR_WIDTH-1:0] BWrAddr,
   input  logic [DATA_WIDTH-1:0] BWrData,
   input  logic [ADDR_WIDTH-1:0] CoreRdAddr1,
   input  logic [ADDR_WIDTH-1:0] CoreRdAddr2,
   input  logic                  CoreRdUse2,
   output logic [DATA_WIDTH-1:0] CoreRdData1,
   output logic [DATA_WIDTH-1:0] CoreRdData2,
   input  logic                  BRdValid,
   output logic                  BRdReady,
   input  logic [ADDR_WIDTH-1:0] BRdAddr,
   output logic [DATA_WIDTH-1:0] BRdData,
   output logic                  BRdDataValid,
   output logic [ADDR_WIDTH-1:0] ReadRegister1,
   output logic [ADDR_WIDTH-1:0] ReadRegister2,
   input  logic [DATA_WIDTH-1:0] ReadData1,
   input  logic [DATA_WIDTH-1:0] ReadData2,
   output logic [ADDR_WIDTH-1:0] WriteRegister,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  RegWrite
);

   localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] brd_data_q, brd_data_d;
   logic                  brd_vld_q, brd_vld_d;
   logic                  run, a_gnt, b_gnt, brd_fire;

   assign run = (state_q == RUN);

   rr_arbiter2 u_wr_arb (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .en      (run),
      .a_valid (AWrValid),
      .b_valid (BWrValid),
      .a_grant (a_gnt),
      .b_grant (b_gnt)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      InitBusy      = 1'b0;
      WriteRegister = '0;
      WriteData     = '0;
      RegWrite      = 1'b0;
      case (state_q)
         INIT: begin
            InitBusy      = 1'b1;
            WriteRegister = cnt_q;
            RegWrite      = 1'b1;
            cnt_d         = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_REG) begin
               state_d = RUN;
               cnt_d   = FIRST_REG;
            end
         end
         RUN: begin
            if (a_gnt) begin
               WriteRegister = AWrAddr;
               WriteData     = AWrData;
            end else if (b_gnt) begin
               WriteRegister = BWrAddr;
               WriteData     = BWrData;
            end
            // Address 0 writes handshake normally but never reach the array.
            RegWrite = (a_gnt || b_gnt) && (WriteRegister != '0);
            if (InitReq) begin
               state_d = INIT;
               cnt_d   = FIRST_REG;
            end
         end
      endcase
   end

   assign AWrReady = a_gnt;
   assign BWrReady = b_gnt;

   assign BRdReady      = run && !CoreRdUse2;
   assign brd_fire      = BRdValid && BRdReady;
   assign ReadRegister1 = CoreRdAddr1;
   assign ReadRegister2 = brd_fire ? BRdAddr : CoreRdAddr2;
   assign CoreRdData1   = ReadData1;
   assign CoreRdData2   = ReadData2;

   always_comb begin
      brd_data_d = brd_fire ? ReadData2 : brd_data_q;
      brd_vld_d  = brd_fire;
   end

   assign BRdData      = brd_data_q;
   assign BRdDataValid = brd_vld_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= INIT;
         cnt_q      <= FIRST_REG;
         brd_data_q <= '0;
         brd_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         brd_data_q <= brd_data_d;
         brd_vld_q  <= brd_vld_d;
      end
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter with a behavioural 32x32 regfile attached.
module tb_regfile_port_arbiter;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        InitReq, InitBusy;
   logic        AWrValid, AWrReady, BWrValid, BWrReady;
   logic [4:0]  AWrAddr, BWrAddr;
   logic [31:0] AWrData, BWrData;
   logic [4:0]  CoreRdAddr1, CoreRdAddr2;
   logic        CoreRdUse2;
   logic [31:0] CoreRdData1, CoreRdData2;
   logic        BRdValid, BRdReady, BRdDataValid;
   logic [4:0]  BRdAddr;
   logic [31:0] BRdData;
   logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
   logic [31:0] ReadData1, ReadData2, WriteData;
   logic        RegWrite;

   regfile_port_arbiter dut (
      .Clk(Clk), .Reset_n(Reset_n), .InitReq(InitReq), .InitBusy(InitBusy),
      .AWrValid(AWrValid), .AWrReady(AWrReady), .AWrAddr(AWrAddr), .AWrData(AWrData),
      .BWrValid(BWrValid), .BWrReady(BWrReady), .BWrAddr(BWrAddr), .BWrData(BWrData),
      .CoreRdAddr1(CoreRdAddr1), .CoreRdAddr2(CoreRdAddr2), .CoreRdUse2(CoreRdUse2),
      .CoreRdData1(CoreRdData1), .CoreRdData2(CoreRdData2),
      .BRdValid(BRdValid), .BRdReady(BRdReady), .BRdAddr(BRdAddr),
      .BRdData(BRdData), .BRdDataValid(BRdDataValid),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite)
   );

   always #5 Clk = ~Clk;

   // Behavioural regfile; reg 0 starts at zero and is only ever written if
   // the controller wrongly raises RegWrite for it.
   logic [31:0] rf [32];
   initial for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : (32'hA5A5_0000 | i);
   always @(posedge Clk) if (RegWrite) rf[WriteRegister] <= WriteData;
   assign ReadData1 = rf[ReadRegister1];
   assign ReadData2 = rf[ReadRegister2];

   int n_pass = 0;
   int n_total = 0;
   logic [31:0] sb_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   // Debug-read scoreboard: expectations are pushed at accept, popped on pulse.
   always @(negedge Clk) begin
      if (Reset_n && BRdDataValid) begin
         if (sb_q.size() == 0) chk("brd_unexpected_pulse", 32'd1, 32'd0);
         else chk("brd_data", BRdData, sb_q.pop_front());
      end
   end

   task automatic step();
      @(posedge Clk); #1;
   endtask

   task automatic sweep_check(input string tag);
      for (int i = 1; i < 32; i++) begin
         @(negedge Clk);
         chk({tag, "_busy"}, {31'd0, InitBusy}, 32'd1);
         chk({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd1);
         chk({tag, "_wreg"}, {27'd0, WriteRegister}, i);
         chk({tag, "_wdata"}, WriteData, 32'd0);
         chk({tag, "_ardy"}, {31'd0, AWrReady}, 32'd0);
         chk({tag, "_brdrdy"}, {31'd0, BRdReady}, 32'd0);
         step();
      end
      @(negedge Clk);
      chk({tag, "_done"}, {31'd0, InitBusy}, 32'd0);
   endtask

   typedef struct {
      logic        a_v, b_v;
      logic        a_rdy, b_rdy, rw;
      logic [4:0]  wreg;
      logic [31:0] wdata;
   } arb_vec_t;
   arb_vec_t vec [8];

   initial begin
      vec[0] = '{1, 1, 1, 0, 1, 5'd3, 32'd10};
      vec[1] = '{1, 1, 0, 1, 1, 5'd4, 32'd20};
      vec[2] = '{1, 1, 1, 0, 1, 5'd3, 32'd10};
      vec[3] = '{1, 1, 0, 1, 1, 5'd4, 32'd20};
      vec[4] = '{1, 0, 1, 0, 1, 5'd3, 32'd10};
      vec[5] = '{1, 0, 1, 0, 1, 5'd3, 32'd10};
      vec[6] = '{0, 0, 0, 0, 0, 5'd0, 32'd0};
      vec[7] = '{1, 1, 0, 1, 1, 5'd4, 32'd20};

      Reset_n = 0; InitReq = 0;
      AWrValid = 0; AWrAddr = 0; AWrData = 0;
      BWrValid = 0; BWrAddr = 0; BWrData = 0;
      CoreRdAddr1 = 0; CoreRdAddr2 = 0; CoreRdUse2 = 0;
      BRdValid = 0; BRdAddr = 0;

      // Reset state, with a core write already pending.
      repeat (2) @(posedge Clk);
      AWrValid = 1; AWrAddr = 5'd2; AWrData = 32'd42;
      @(negedge Clk);
      chk("rst_busy", {31'd0, InitBusy}, 32'd1);
      chk("rst_ardy", {31'd0, AWrReady}, 32'd0);
      chk("rst_bwrdy", {31'd0, BWrReady}, 32'd0);
      chk("rst_brdrdy", {31'd0, BRdReady}, 32'd0);
      chk("rst_brdata", BRdData, 32'd0);
      chk("rst_brvld", {31'd0, BRdDataValid}, 32'd0);
      step();
      Reset_n = 1;
      sweep_check("sweep1");

      // Held request is granted on the first RUN cycle.
      chk("a_first_rdy", {31'd0, AWrReady}, 32'd1);
      chk("a_first_rw", {31'd0, RegWrite}, 32'd1);
      chk("a_first_wreg", {27'd0, WriteRegister}, 32'd2);
      chk("a_first_wdata", WriteData, 32'd42);
      step();
      AWrValid = 0; CoreRdAddr1 = 5'd2;
      #1 chk("rd_reg2", CoreRdData1, 32'd42);

      // Debug write to reg 0: accepted, no array write; pointer moves to A.
      BWrValid = 1; BWrAddr = 5'd0; BWrData = 32'd15;
      @(negedge Clk);
      chk("b0_rdy", {31'd0, BWrReady}, 32'd1);
      chk("b0_rw", {31'd0, RegWrite}, 32'd0);
      step();
      BWrValid = 0; CoreRdAddr1 = 5'd0;
      #1 chk("rd_reg0", CoreRdData1, 32'd0);

      // Arbitration table.
      AWrAddr = 5'd3; AWrData = 32'd10; BWrAddr = 5'd4; BWrData = 32'd20;
      for (int i = 0; i < 8; i++) begin
         AWrValid = vec[i].a_v; BWrValid = vec[i].b_v;
         @(negedge Clk);
         chk($sformatf("arb%0d_ardy", i), {31'd0, AWrReady}, {31'd0, vec[i].a_rdy});
         chk($sformatf("arb%0d_brdy", i), {31'd0, BWrReady}, {31'd0, vec[i].b_rdy});
         chk($sformatf("arb%0d_rw", i), {31'd0, RegWrite}, {31'd0, vec[i].rw});
         chk($sformatf("arb%0d_wreg", i), {27'd0, WriteRegister}, {27'd0, vec[i].wreg});
         chk($sformatf("arb%0d_wdata", i), WriteData, vec[i].wdata);
         step();
      end
      AWrValid = 0; BWrValid = 0;

      // Debug read blocked by core use of port 2, then served.
      AWrValid = 1; AWrAddr = 5'd5; AWrData = 32'd77;
      @(negedge Clk);
      chk("w5_rdy", {31'd0, AWrReady}, 32'd1);
      step();
      AWrValid = 0;
      CoreRdUse2 = 1; CoreRdAddr2 = 5'd9; BRdValid = 1; BRdAddr = 5'd5;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         chk("brd_blocked_rdy", {31'd0, BRdReady}, 32'd0);
         chk("brd_blocked_rr2", {27'd0, ReadRegister2}, 32'd9);
         chk("brd_blocked_vld", {31'd0, BRdDataValid}, 32'd0);
         step();
      end
      CoreRdUse2 = 0;
      @(negedge Clk);
      chk("brd_rdy", {31'd0, BRdReady}, 32'd1);
      chk("brd_rr2", {27'd0, ReadRegister2}, 32'd5);
      if (BRdReady) sb_q.push_back(32'd77);
      step();
      BRdValid = 0;
      @(negedge Clk);
      chk("brd_pulse_hi", {31'd0, BRdDataValid}, 32'd1);
      step();
      @(negedge Clk);
      chk("brd_pulse_lo", {31'd0, BRdDataValid}, 32'd0);

      // Back-to-back debug reads.
      step();
      BRdValid = 1; BRdAddr = 5'd2;
      @(negedge Clk);
      chk("b2b0_rdy", {31'd0, BRdReady}, 32'd1);
      if (BRdReady) sb_q.push_back(32'd42);
      step();
      BRdAddr = 5'd3;
      @(negedge Clk);
      chk("b2b1_rdy", {31'd0, BRdReady}, 32'd1);
      if (BRdReady) sb_q.push_back(32'd10);
      step();
      BRdAddr = 5'd4;
      @(negedge Clk);
      chk("b2b2_rdy", {31'd0, BRdReady}, 32'd1);
      if (BRdReady) sb_q.push_back(32'd20);
      step();
      BRdValid = 0;
      repeat (2) step();
      chk("sb_drained", sb_q.size(), 32'd0);

      // InitReq in RUN with a same-cycle write, then reset mid-sweep.
      repeat (10) step();
      InitReq = 1; AWrValid = 1; AWrAddr = 5'd7; AWrData = 32'd99;
      @(negedge Clk);
      chk("ireq_busy", {31'd0, InitBusy}, 32'd0);
      chk("ireq_ardy", {31'd0, AWrReady}, 32'd1);
      chk("ireq_wreg", {27'd0, WriteRegister}, 32'd7);
      step();
      InitReq = 0; AWrValid = 0;
      @(negedge Clk);
      chk("ireq_sweep_busy", {31'd0, InitBusy}, 32'd1);
      chk("ireq_sweep_wreg", {27'd0, WriteRegister}, 32'd1);
      chk("ireq_w7_landed", rf[7], 32'd99);
      repeat (5) step();
      Reset_n = 0;
      #1;
      chk("midrst_busy", {31'd0, InitBusy}, 32'd1);
      chk("midrst_wreg", {27'd0, WriteRegister}, 32'd1);
      step();
      Reset_n = 1;
      sweep_check("sweep2");
      step();
      for (int i = 1; i < 32; i++) begin
         CoreRdAddr1 = i[4:0];
         #1 chk($sformatf("clr_reg%0d", i), CoreRdData1, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
